// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, branch squash and bounded data-memory waits
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             id_rsAddress,
  input  logic [4:0]             id_rtAddress,
  input  logic                   id_usesRs,
  input  logic                   id_usesRt,
  input  logic                   id_branchTaken,
  input  logic                   ex_isLoad,
  input  logic [4:0]             ex_registerWriteAddress,
  input  logic                   mem_isMemoryAccess,
  input  logic                   mem_ready,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_stall,
  output logic                   idex_flush,
  output logic                   exmem_stall,
  output logic                   memwb_bubble,
  output logic                   mem_error,
  output logic [COUNT_WIDTH-1:0] stall_cycles
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t                 state_q, state_d;
  logic [7:0]             wait_q, wait_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   mem_hold, mem_freeze, mem_abort, freeze, run, load_use;
  always_comb begin
    mem_hold     = mem_isMemoryAccess && !mem_ready;
    mem_freeze   = (state_q == RUN) ? mem_hold : mem_hold && (wait_q < 8'(MEM_TIMEOUT));
    mem_abort    = (state_q == MEM_WAIT) && mem_hold && (wait_q == 8'(MEM_TIMEOUT));
    freeze       = !reset && mem_freeze;
    run          = !reset && !mem_freeze && !mem_abort;
    load_use     = run && ex_isLoad && (ex_registerWriteAddress != 5'd0) &&
                   ((id_usesRs && id_rsAddress == ex_registerWriteAddress) ||
                    (id_usesRt && id_rtAddress == ex_registerWriteAddress));
    pc_stall     = freeze || load_use;
    ifid_stall   = freeze || load_use;
    ifid_flush   = run && !load_use && id_branchTaken;
    idex_stall   = freeze;
    idex_flush   = load_use;
    exmem_stall  = freeze;
    memwb_bubble = freeze || (!reset && mem_abort);
    mem_error    = err_q;
    stall_cycles = cnt_q;
    state_d      = (state_q == RUN) ? (mem_hold ? MEM_WAIT : RUN) : (mem_freeze ? MEM_WAIT : RUN);
    wait_d       = (state_q == RUN) ? (mem_hold ? 8'd1 : 8'd0) : (mem_freeze ? wait_q + 8'd1 : 8'd0);
    err_d        = err_q || mem_abort;
    cnt_d        = (pc_stall && !(&cnt_q)) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
